// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU datapath multiplier.
//   - DEFAULT_WIDTH : operand width used when no override is given
//   - state_t       : multiplier sequencer states (IDLE/RUN/DONE)
//   - BOOTH_*       : radix-2 Booth recode of the pair {Q[0], q_1}
package cpu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // {Q[0], q_1} recode: 01 -> add M, 10 -> subtract M, 00/11 -> no change.
  localparam logic [1:0] BOOTH_HOLD_0 = 2'b00;
  localparam logic [1:0] BOOTH_ADD    = 2'b01;
  localparam logic [1:0] BOOTH_SUB    = 2'b10;
  localparam logic [1:0] BOOTH_HOLD_1 = 2'b11;

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth step.
// Ports:
//   a        in  WIDTH+1  accumulator
//   q        in  WIDTH    multiplier / low product bits
//   q_1      in  1        bit to the right of q
//   m        in  WIDTH    multiplicand (two's complement)
//   a_next   out WIDTH+1  accumulator after add/sub and arithmetic shift
//   q_next   out WIDTH    q after shift
//   q_1_next out 1        new q_1 (old q[0])
module booth_step
  import cpu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] q,
  input  logic             q_1,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   a_next,
  output logic [WIDTH-1:0] q_next,
  output logic             q_1_next
);

  logic [WIDTH:0] m_ext;
  logic [WIDTH:0] sum;

  // The accumulator is one bit wider than M so that subtracting the most
  // negative multiplicand cannot wrap.
  assign m_ext = {m[WIDTH-1], m};

  always_comb begin
    sum = a;
    case ({q[0], q_1})
      BOOTH_ADD: sum = a + m_ext;
      BOOTH_SUB: sum = a - m_ext;
      default:   sum = a;
    endcase
  end

  // Arithmetic right shift of {sum, q, q_1}, replicating the accumulator MSB.
  assign a_next   = {sum[WIDTH], sum[WIDTH:1]};
  assign q_next   = {sum[0], q[WIDTH-1:1]};
  assign q_1_next = q[0];

endmodule

// File: rtl/booth_mul_unit.sv
// Sequential signed radix-2 Booth multiplier, one step per clock.
// Ports:
//   clock   in  1      system clock (rising edge)
//   clear   in  1      synchronous active-high reset
//   start   in  1      request, sampled in IDLE or DONE
//   y_in    in  WIDTH  multiplicand, two's complement
//   bus_in  in  WIDTH  multiplier, two's complement
//   busy    out 1      high while an operation is running
//   done    out 1      one-cycle completion pulse
//   hi      out WIDTH  product bits [2*WIDTH-1:WIDTH]
//   lo      out WIDTH  product bits [WIDTH-1:0]
//
// Handshake: the requester raises start; it is taken on a rising edge only
// when the unit is in IDLE or DONE (busy low). The unit then holds busy high
// for WIDTH cycles, ignoring start, and on the edge that ends the last step
// loads hi/lo, drops busy and raises done for exactly one cycle. start held
// high through that DONE cycle launches the next operation with no idle gap.
module booth_mul_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] y_in,
  input  logic [WIDTH-1:0] bus_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] m_q;
  logic [WIDTH:0]   a_q;
  logic [WIDTH-1:0] q_q;
  logic             q_1_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH:0]   a_next;
  logic [WIDTH-1:0] q_next;
  logic             q_1_next;

  logic load;
  logic step;
  logic last_step;

  booth_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .a        (a_q),
    .q        (q_q),
    .q_1      (q_1_q),
    .m        (m_q),
    .a_next   (a_next),
    .q_next   (q_next),
    .q_1_next (q_1_next)
  );

  // Next-state and control decode.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    step      = 1'b0;
    last_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          last_step = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath, counter and result registers. busy/done are registered from
  // the next state so they line up exactly with the state register.
  always_ff @(posedge clock) begin
    if (clear) begin
      m_q    <= '0;
      a_q    <= '0;
      q_q    <= '0;
      q_1_q  <= 1'b0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_d == RUN);
      done_q <= (state_d == DONE);
      if (load) begin
        m_q   <= y_in;
        q_q   <= bus_in;
        a_q   <= '0;
        q_1_q <= 1'b0;
        cnt_q <= CNT_W'(WIDTH);
      end else if (step) begin
        a_q   <= a_next;
        q_q   <= q_next;
        q_1_q <= q_1_next;
        cnt_q <= cnt_q - CNT_W'(1);
        // The final step's result goes straight to HI/LO on the same edge.
        if (last_step) begin
          hi_q <= a_next[WIDTH-1:0];
          lo_q <= q_next;
        end
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
